// File: rtl/img_rsz_pxl_fwd_pkg.sv
// Shared types and constants for the resized-pixel forwarder.
package img_rsz_pxl_fwd_pkg;

  localparam int unsigned RszFwdOrderRaster = 0;
  localparam int unsigned RszFwdOrderFfs    = 1;

  typedef enum logic [1:0] {
    FwdIdle,
    FwdRun,
    FwdDrain
  } fwd_state_e;

endpackage

// File: rtl/img_rsz_pxl_fwd_skid2.sv
// Generic 2-entry valid/ready buffer; head entry drives the output and holds until popped.
module img_rsz_pxl_fwd_skid2 #(
  parameter type T = logic
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic push_i,
  input  T     push_data_i,
  output logic full_o,
  output logic vld_o,
  input  logic rdy_i,
  output T     data_o
);

  logic [1:0] occ_q, occ_d;
  T           head_q, head_d, tail_q, tail_d;
  logic       pop;

  assign pop    = vld_o & rdy_i;
  assign vld_o  = (occ_q != 2'd0);
  assign full_o = (occ_q == 2'd2);
  assign data_o = head_q;

  always_comb begin
    occ_d  = occ_q;
    head_d = head_q;
    tail_d = tail_q;
    case ({push_i, pop})
      2'b10: begin
        if (occ_q == 2'd0) begin
          head_d = push_data_i;
          occ_d  = 2'd1;
        end else begin
          tail_d = push_data_i;
          occ_d  = 2'd2;
        end
      end
      2'b01: begin
        if (occ_q == 2'd2) head_d = tail_q;
        occ_d = occ_q - 2'd1;
      end
      // Only reachable at occupancy 1: the popped head is replaced in place.
      2'b11:   head_d = push_data_i;
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      occ_q  <= 2'd0;
      head_q <= '0;
      tail_q <= '0;
    end else begin
      occ_q  <= occ_d;
      head_q <= head_d;
      tail_q <= tail_d;
    end
  end

endmodule

// File: rtl/img_rsz_pxl_fwd.sv
// Resized-pixel forwarder: flushes executed blocks in raster or first-set order into a 2-entry
// skid buffer. Optional statistics counters are enabled by defining IMG_RSZ_FWD_STAT_EN.
module img_rsz_pxl_fwd
  import img_rsz_pxl_fwd_pkg::*;
#(
  parameter int unsigned RSZ_W     = 4,
  parameter int unsigned RSZ_H     = 4,
  parameter int unsigned COLOR_NUM = 3,
  parameter int unsigned COLOR_W   = 8,
  parameter int unsigned FWD_ORDER = 0,
  localparam int unsigned X_W      = $clog2(RSZ_W),
  localparam int unsigned Y_W      = $clog2(RSZ_H),
  localparam int unsigned CNT_W    = $clog2(RSZ_W * RSZ_H + 1),
  localparam int unsigned PXL_W    = COLOR_NUM * COLOR_W
) (
  input  logic                              clk_i,
  input  logic                              rst_i,
  input  logic                              frm_start_i,
  input  logic [RSZ_H-1:0][RSZ_W-1:0]       blk_is_exec_i,
  input  logic [PXL_W-1:0]                  flush_rsz_pxl_data_i,
  output logic [RSZ_W-1:0]                  flush_blk_x_msk_o,
  output logic [RSZ_H-1:0]                  flush_blk_y_msk_o,
  output logic                              flush_vld_o,
  output logic [PXL_W-1:0]                  rsz_pxl_data_o,
  output logic [X_W-1:0]                    rsz_pxl_x_o,
  output logic [Y_W-1:0]                    rsz_pxl_y_o,
  output logic                              rsz_pxl_last_o,
  output logic                              rsz_pxl_vld_o,
  input  logic                              rsz_pxl_rdy_i,
  output logic                              fwd_busy_o
`ifdef IMG_RSZ_FWD_STAT_EN
  ,
  output logic [15:0]                       frm_cnt_o,
  output logic [15:0]                       stall_cnt_o
`endif
);

  localparam logic [CNT_W-1:0] CntLast = CNT_W'(RSZ_W * RSZ_H - 1);

  typedef struct packed {
    logic [PXL_W-1:0] data;
    logic [X_W-1:0]   x;
    logic [Y_W-1:0]   y;
    logic             last;
  } rsz_fwd_ent_t;

  if ((FWD_ORDER != RszFwdOrderRaster) && (FWD_ORDER != RszFwdOrderFfs)) begin : gen_order_chk
    $error("img_rsz_pxl_fwd: FWD_ORDER must be 0 (raster) or 1 (first-set)");
  end

  fwd_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             arm, skid_full, cand_vld;
  logic [X_W-1:0]   cand_x;
  logic [Y_W-1:0]   cand_y;
  rsz_fwd_ent_t     push_ent, out_ent;

  assign arm = (state_q == FwdIdle) & frm_start_i;

  if (FWD_ORDER == RszFwdOrderFfs) begin : gen_ffs
    // Scan from the highest index down so the lowest Y, then lowest X, wins.
    always_comb begin
      cand_vld = 1'b0;
      cand_x   = '0;
      cand_y   = '0;
      for (int y = int'(RSZ_H) - 1; y >= 0; y--) begin
        for (int x = int'(RSZ_W) - 1; x >= 0; x--) begin
          if (blk_is_exec_i[y][x]) begin
            cand_vld = 1'b1;
            cand_x   = X_W'(x);
            cand_y   = Y_W'(y);
          end
        end
      end
    end
  end else begin : gen_raster
    localparam logic [X_W-1:0] XMax = X_W'(RSZ_W - 1);
    localparam logic [Y_W-1:0] YMax = Y_W'(RSZ_H - 1);

    logic [X_W-1:0] cur_x_q, cur_x_d;
    logic [Y_W-1:0] cur_y_q, cur_y_d;

    assign cand_vld = blk_is_exec_i[cur_y_q][cur_x_q];
    assign cand_x   = cur_x_q;
    assign cand_y   = cur_y_q;

    always_comb begin
      cur_x_d = cur_x_q;
      cur_y_d = cur_y_q;
      if (arm) begin
        cur_x_d = '0;
        cur_y_d = '0;
      end else if (flush_vld_o) begin
        if (cur_x_q == XMax) begin
          cur_x_d = '0;
          cur_y_d = (cur_y_q == YMax) ? '0 : cur_y_q + 1'b1;
        end else begin
          cur_x_d = cur_x_q + 1'b1;
        end
      end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        cur_x_q <= '0;
        cur_y_q <= '0;
      end else begin
        cur_x_q <= cur_x_d;
        cur_y_q <= cur_y_d;
      end
    end
  end

  assign flush_vld_o = (state_q == FwdRun) & ~skid_full & cand_vld;

  always_comb begin
    flush_blk_x_msk_o = '0;
    flush_blk_y_msk_o = '0;
    if (flush_vld_o) begin
      flush_blk_x_msk_o[cand_x] = 1'b1;
      flush_blk_y_msk_o[cand_y] = 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      FwdIdle: begin
        if (arm) begin
          state_d = FwdRun;
          cnt_d   = '0;
        end
      end
      FwdRun: begin
        if (flush_vld_o) begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CntLast) state_d = FwdDrain;
        end
      end
      FwdDrain: begin
        if (!rsz_pxl_vld_o) state_d = FwdIdle;
      end
      default: state_d = FwdIdle;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= FwdIdle;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign push_ent.data = flush_rsz_pxl_data_i;
  assign push_ent.x    = cand_x;
  assign push_ent.y    = cand_y;
  assign push_ent.last = (cnt_q == CntLast);

  img_rsz_pxl_fwd_skid2 #(
    .T (rsz_fwd_ent_t)
  ) u_skid (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .push_i      (flush_vld_o),
    .push_data_i (push_ent),
    .full_o      (skid_full),
    .vld_o       (rsz_pxl_vld_o),
    .rdy_i       (rsz_pxl_rdy_i),
    .data_o      (out_ent)
  );

  assign rsz_pxl_data_o = out_ent.data;
  assign rsz_pxl_x_o    = out_ent.x;
  assign rsz_pxl_y_o    = out_ent.y;
  assign rsz_pxl_last_o = out_ent.last;
  assign fwd_busy_o     = (state_q != FwdIdle);

`ifdef IMG_RSZ_FWD_STAT_EN
  logic [15:0] frm_cnt_q, stall_cnt_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      frm_cnt_q   <= '0;
      stall_cnt_q <= '0;
    end else begin
      if (rsz_pxl_vld_o & rsz_pxl_rdy_i & rsz_pxl_last_o) frm_cnt_q <= frm_cnt_q + 16'd1;
      if (arm) begin
        stall_cnt_q <= '0;
      end else if (rsz_pxl_vld_o & ~rsz_pxl_rdy_i & (stall_cnt_q != 16'hFFFF)) begin
        stall_cnt_q <= stall_cnt_q + 16'd1;
      end
    end
  end

  assign frm_cnt_o   = frm_cnt_q;
  assign stall_cnt_o = stall_cnt_q;
`endif

endmodule
